// File: rtl/draw_control_if.sv
// Request and drawer-side signal bundle of draw_control.
// The master modport is the controller; the slave modport is game logic plus the drawer.
interface draw_control_if #(
  parameter int CNT_W = 15
);
  logic             req_board;
  logic             req_result;
  logic [1:0]       result;
  logic             new_game;
  logic [CNT_W-1:0] screenCycle;
  logic             drawBoard;
  logic             drawRWin;
  logic             drawYWin;
  logic             gameTie;
  logic             en_screenCycle;
  logic             plot;
  logic             busy;
  logic             frame_done;

  modport master (
    input  req_board, req_result, result, new_game, screenCycle,
    output drawBoard, drawRWin, drawYWin, gameTie, en_screenCycle, plot, busy, frame_done
  );

  modport slave (
    output req_board, req_result, result, new_game, screenCycle,
    input  drawBoard, drawRWin, drawYWin, gameTie, en_screenCycle, plot, busy, frame_done
  );
endinterface

// File: rtl/draw_control.sv
// Sequencing FSM for the full-screen image drawer: serves board/result redraw requests one frame
// at a time. Optional result-screen hold is enabled with the macro HOLD_RESULT_EN.
module draw_control #(
  parameter int FRAME_PIXELS = 19200,
  parameter int CNT_W        = 15
) (
  input  logic           clk,
  input  logic           resetn,
  draw_control_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  // Result codes 01/10/11 double as select codes; 00 (never a valid result) selects the board.
  localparam logic [1:0] SEL_BOARD = 2'b00;
  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(FRAME_PIXELS - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] res_q, res_d;
  logic       pend_board_q, pend_board_d;
  logic       pend_res_q, pend_res_d;
  logic       res_req_s;
  logic       hold_eff_s;
  logic       active_s;
  logic       draw_board_q, draw_board_d;
  logic       draw_rwin_q, draw_rwin_d;
  logic       draw_ywin_q, draw_ywin_d;
  logic       game_tie_q, game_tie_d;
  logic       en_screen_cycle_q, en_screen_cycle_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

`ifdef HOLD_RESULT_EN
  logic hold_q, hold_d;

  // Hold latches after a completed result frame; new_game releases it.
  always_comb begin
    hold_eff_s = hold_q & ~bus.new_game;
    if ((state_q == DONE) && (sel_q != SEL_BOARD)) begin
      hold_d = 1'b1;
    end else begin
      hold_d = hold_eff_s;
    end
  end

  // Hold register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_new_game;
  assign unused_new_game = bus.new_game;
  assign hold_eff_s      = 1'b0;
`endif

  // Request latching and frame sequencing; a request in this cycle is visible to IDLE at once.
  always_comb begin
    res_req_s    = bus.req_result & (bus.result != 2'b00);
    res_d        = res_req_s ? bus.result : res_q;
    pend_res_d   = pend_res_q | res_req_s;
    pend_board_d = (pend_board_q | bus.req_board) & ~hold_eff_s;
    state_d      = state_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        if (pend_res_d) begin
          state_d    = ARM;
          sel_d      = res_d;
          pend_res_d = 1'b0;
        end else if (pend_board_d) begin
          state_d      = ARM;
          sel_d        = SEL_BOARD;
          pend_board_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (bus.screenCycle == {CNT_W{1'b0}}) begin
          state_d = DRAW;
        end else begin
          state_d = ARM;
        end
      end
      DRAW: begin
        if (bus.screenCycle == LAST_PIXEL) begin
          state_d = DONE;
        end else begin
          state_d = DRAW;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    active_s          = (state_d == ARM) | (state_d == DRAW);
    draw_board_d      = active_s & (sel_d == SEL_BOARD);
    draw_rwin_d       = active_s & (sel_d == 2'b01);
    draw_ywin_d       = active_s & (sel_d == 2'b10);
    game_tie_d        = active_s & (sel_d == 2'b11);
    en_screen_cycle_d = (state_d == DRAW);
    plot_d            = (state_d == DRAW);
    busy_d            = (state_d != IDLE);
    frame_done_d      = (state_d == DONE);
  end

  // State, pending requests and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= IDLE;
      sel_q             <= SEL_BOARD;
      res_q             <= 2'b00;
      pend_board_q      <= 1'b0;
      pend_res_q        <= 1'b0;
      draw_board_q      <= 1'b0;
      draw_rwin_q       <= 1'b0;
      draw_ywin_q       <= 1'b0;
      game_tie_q        <= 1'b0;
      en_screen_cycle_q <= 1'b0;
      plot_q            <= 1'b0;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      sel_q             <= sel_d;
      res_q             <= res_d;
      pend_board_q      <= pend_board_d;
      pend_res_q        <= pend_res_d;
      draw_board_q      <= draw_board_d;
      draw_rwin_q       <= draw_rwin_d;
      draw_ywin_q       <= draw_ywin_d;
      game_tie_q        <= game_tie_d;
      en_screen_cycle_q <= en_screen_cycle_d;
      plot_q            <= plot_d;
      busy_q            <= busy_d;
      frame_done_q      <= frame_done_d;
    end
  end

  assign bus.drawBoard      = draw_board_q;
  assign bus.drawRWin       = draw_rwin_q;
  assign bus.drawYWin       = draw_ywin_q;
  assign bus.gameTie        = game_tie_q;
  assign bus.en_screenCycle = en_screen_cycle_q;
  assign bus.plot           = plot_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = frame_done_q;
endmodule
